// File: rtl/doomsoc_rst_pkg.sv
// Shared reset-sequencing definitions: sequencer state encoding, debug
// counter width and the saturating-increment helper used for event counts.
package doomsoc_rst_pkg;

   localparam int LOCK_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_SYS       = 2'd2,
      ST_RUN       = 2'd3
   } rst_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] v);
      logic [LOCK_CNT_W-1:0] r;
      if (v == {LOCK_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit. Clears to 0 on
// reset so a not-yet-synchronised input always reads as inactive.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// Reset sequencer behind the system PLL: waits for a stable lock, then
// releases the system reset and, a fixed time later, the peripheral reset.
// Sustained lock loss or a software request re-runs the sequence.
module pll_rst_ctrl
   import doomsoc_rst_pkg::*;
#(
   parameter int SYNC_STAGES          = 2,
   parameter int LOCK_STABLE_CYCLES   = 1024,
   parameter int SYS_TO_PERIPH_CYCLES = 16,
   parameter int LOSS_FILTER          = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  soft_rst_req,
   output logic                  rst_n_sys,
   output logic                  rst_n_periph,
   output logic                  ready,
   output logic [LOCK_CNT_W-1:0] lock_loss_count
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > SYS_TO_PERIPH_CYCLES) ?
                            LOCK_STABLE_CYCLES : SYS_TO_PERIPH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int FILT_W  = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SYS_LAST  = CNT_W'(SYS_TO_PERIPH_CYCLES - 1);
   localparam logic [FILT_W-1:0] FILT_ZERO = FILT_W'(0);
   localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);

   logic                  locked_s;
   rst_state_t            state_r, state_nx_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [FILT_W-1:0]     filt_r, filt_nx_s;
   logic                  hold_r, hold_nx_s;
   logic [LOCK_CNT_W-1:0] loss_cnt_r, loss_cnt_nx_s;
   logic                  rst_n_sys_r, rst_n_periph_r, ready_r;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Next-state, shared counter, loss filter and loss-event count.
   // hold marks the first STABLE cycle after a software restart: the
   // counter stays at zero for that cycle, so a restart takes one edge
   // longer than a fresh lock acquisition.
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r;
      filt_nx_s     = FILT_ZERO;
      hold_nx_s     = 1'b0;
      loss_cnt_nx_s = loss_cnt_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            cnt_nx_s = CNT_ZERO;
            if (locked_s) begin
               state_nx_s = ST_STABLE;
            end else begin
               state_nx_s = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_nx_s = ST_WAIT_LOCK;
               cnt_nx_s   = CNT_ZERO;
            end else if (soft_rst_req || hold_r) begin
               cnt_nx_s = CNT_ZERO;
            end else if (cnt_r == LOCK_LAST) begin
               state_nx_s = ST_SYS;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               cnt_nx_s = cnt_r + CNT_ONE;
            end
         end
         ST_SYS, ST_RUN: begin
            if (!locked_s && (filt_r == FILT_LAST)) begin
               // Lock loss takes priority over a coincident software request.
               state_nx_s    = ST_WAIT_LOCK;
               cnt_nx_s      = CNT_ZERO;
               loss_cnt_nx_s = sat_inc(loss_cnt_r);
            end else if (soft_rst_req) begin
               state_nx_s = ST_STABLE;
               cnt_nx_s   = CNT_ZERO;
               hold_nx_s  = 1'b1;
            end else begin
               if (locked_s) begin
                  filt_nx_s = FILT_ZERO;
               end else begin
                  filt_nx_s = filt_r + FILT_ONE;
               end
               if (state_r == ST_SYS) begin
                  if (cnt_r == SYS_LAST) begin
                     state_nx_s = ST_RUN;
                     cnt_nx_s   = CNT_ZERO;
                  end else begin
                     cnt_nx_s = cnt_r + CNT_ONE;
                  end
               end else begin
                  cnt_nx_s = cnt_r;
               end
            end
         end
         default: begin
            state_nx_s = ST_WAIT_LOCK;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase
   end

   // Sequencer state and registered reset/ready outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_WAIT_LOCK;
         cnt_r          <= CNT_ZERO;
         filt_r         <= FILT_ZERO;
         hold_r         <= 1'b0;
         loss_cnt_r     <= {LOCK_CNT_W{1'b0}};
         rst_n_sys_r    <= 1'b0;
         rst_n_periph_r <= 1'b0;
         ready_r        <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         cnt_r          <= cnt_nx_s;
         filt_r         <= filt_nx_s;
         hold_r         <= hold_nx_s;
         loss_cnt_r     <= loss_cnt_nx_s;
         rst_n_sys_r    <= (state_nx_s == ST_SYS) || (state_nx_s == ST_RUN);
         rst_n_periph_r <= (state_nx_s == ST_RUN);
         ready_r        <= (state_nx_s == ST_RUN);
      end
   end

   assign rst_n_sys       = rst_n_sys_r;
   assign rst_n_periph    = rst_n_periph_r;
   assign ready           = ready_r;
   assign lock_loss_count = loss_cnt_r;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: directed sequencing scenarios plus randomized lock
// and software-request traffic, checked every cycle against a model that
// tracks "edges of continuous good lock since the last restart".
module tb_pll_rst_ctrl;

   localparam int SYNC = 2;
   localparam int LSC  = 1024;
   localparam int S2P  = 16;
   localparam int LOSS = 4;

   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic rst_n = 1'b0;
   logic pll_locked = 1'b0;
   logic soft_rst_req = 1'b0;
   logic lk2 = 1'b0;
   logic soft2 = 1'b0;

   logic       rst_n_sys, rst_n_periph, ready;
   logic [7:0] lock_loss_count;
   logic       sys2, per2, rdy2;
   logic [7:0] cnt2;

   pll_rst_ctrl #(
      .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC),
      .SYS_TO_PERIPH_CYCLES(S2P), .LOSS_FILTER(LOSS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
      .rst_n_sys(rst_n_sys), .rst_n_periph(rst_n_periph), .ready(ready),
      .lock_loss_count(lock_loss_count)
   );

   // Small-parameter copy so that saturating the loss counter stays short.
   pll_rst_ctrl #(
      .SYNC_STAGES(3), .LOCK_STABLE_CYCLES(2),
      .SYS_TO_PERIPH_CYCLES(2), .LOSS_FILTER(1)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .pll_locked(lk2), .soft_rst_req(soft2),
      .rst_n_sys(sys2), .rst_n_periph(per2), .ready(rdy2),
      .lock_loss_count(cnt2)
   );

   // Gateable free-running clock.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   int total = 0;
   int bad = 0;
   int e = 0;

   // Reference model: m_age = -1 while waiting for lock, otherwise edges of
   // good lock counted since (re)start, saturating once the sequence is done.
   int   m_age, m_low, m_cnt;
   logic sh [SYNC];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, e, got, exp);
      end
   endtask

   task automatic model_reset();
      m_age = -1;
      m_low = 0;
      m_cnt = 0;
      for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
   endtask

   task automatic model_step();
      logic ls;
      ls = sh[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = pll_locked;
      if (m_age < 0) begin
         m_low = 0;
         if (ls) m_age = 0;
      end else if (m_age < LSC) begin
         m_low = 0;
         if (!ls) m_age = -1;
         else if (soft_rst_req) m_age = 0;
         else m_age++;
      end else begin
         if (!ls) m_low++;
         else m_low = 0;
         if (m_low == LOSS) begin
            m_age = -1;
            m_low = 0;
            if (m_cnt < 255) m_cnt++;
         end else if (soft_rst_req) begin
            m_age = -1;
            m_low = 0;
         end else if (m_age < LSC + S2P) begin
            m_age++;
         end
      end
   endtask

   function automatic int model_vec();
      int v;
      v = m_cnt;
      if (m_age >= LSC) v += 1024;
      if (m_age >= LSC + S2P) v += 512 + 256;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      e++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      check("outputs", int'({rst_n_sys, rst_n_periph, ready, lock_loss_count}), model_vec());
   endtask

   // Tick until the selected output (0: rst_n_sys, 1: ready) reaches lvl.
   task automatic wait_out(input int sel, input logic lvl, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if ((sel == 0 && rst_n_sys == lvl) || (sel == 1 && ready == lvl)) begin
            at = e;
            break;
         end
      end
   endtask

   initial begin
      int at, s, d, j, k, burst;
      model_reset();

      // Power-on reset state.
      repeat (3) tick();
      check("reset_vals", int'({rst_n_sys, rst_n_periph, ready, lock_loss_count}), 0);

      // First lock: edge 0 is the first edge sampling pll_locked=1.
      rst_n = 1'b1;
      pll_locked = 1'b1;
      e = -1;
      wait_out(0, 1'b1, 1100, at);
      check("sys_rise", at, 1026);
      wait_out(1, 1'b1, 100, at);
      check("ready_rise", at, 1042);
      check("periph_rise", int'(rst_n_periph), 1);
      check("count_zero", int'(lock_loss_count), 0);

      // Software restart from RUN.
      soft_rst_req = 1'b1;
      tick();
      s = e;
      soft_rst_req = 1'b0;
      check("soft_sys_low", int'(rst_n_sys), 0);
      check("soft_ready_low", int'(ready), 0);
      wait_out(0, 1'b1, 1100, at);
      check("soft_sys_rise", at, s + 1025);
      wait_out(1, 1'b1, 100, at);
      check("soft_count", int'(lock_loss_count), 0);

      // One-cycle dropout part-way through STABLE forces a full new wait.
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      repeat (500) tick();
      pll_locked = 1'b0;
      tick();
      d = e;
      pll_locked = 1'b1;
      wait_out(0, 1'b1, 1200, at);
      check("stable_drop_rise", at, d + 1 + 1026);
      wait_out(1, 1'b1, 100, at);

      // Short dropout in RUN is filtered out.
      pll_locked = 1'b0;
      repeat (2) tick();
      pll_locked = 1'b1;
      repeat (10) tick();
      check("glitch_ready", int'(ready), 1);
      check("glitch_count", int'(lock_loss_count), 0);

      // Sustained loss in RUN.
      pll_locked = 1'b0;
      tick();
      j = e;
      wait_out(0, 1'b0, 20, at);
      check("loss_fall", at, j + 5);
      check("loss_periph", int'(rst_n_periph), 0);
      check("loss_count", int'(lock_loss_count), 1);
      repeat (4) tick();
      pll_locked = 1'b1;
      tick();
      k = e;
      wait_out(1, 1'b1, 1100, at);
      check("relock_ready", at, k + 1042);

      // Lock loss and software request on the same edge: loss wins.
      pll_locked = 1'b0;
      tick();
      j = e;
      repeat (4) tick();
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      check("combo_sys", int'(rst_n_sys), 0);
      check("combo_count", int'(lock_loss_count), 2);
      repeat (3) tick();
      pll_locked = 1'b1;
      tick();
      k = e;
      wait_out(0, 1'b1, 1100, at);
      check("combo_relock", at, k + 1026);

      // Asynchronous reset in SYS with the clock stopped.
      repeat (3) tick();
      check("in_sys", int'({rst_n_sys, ready}), 2);
      @(negedge clk);
      clk_en = 1'b0;
      #20;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", int'({rst_n_sys, rst_n_periph, ready, lock_loss_count}), 0);
      model_reset();
      #20;
      clk_en = 1'b1;
      tick();
      rst_n = 1'b1;

      // Randomized lock dropouts and software requests.
      burst = 0;
      for (int n = 0; n < 20000; n++) begin
         if (burst > 0) begin
            pll_locked = 1'b0;
            burst--;
         end else begin
            pll_locked = 1'b1;
            if ($urandom_range(0, 1499) == 0) burst = $urandom_range(1, 8);
         end
         soft_rst_req = ($urandom_range(0, 1999) == 0);
         tick();
      end
      pll_locked = 1'b1;
      soft_rst_req = 1'b0;

      // Drive 300 lock losses into the small instance.
      for (int i = 0; i < 300; i++) begin
         lk2 = 1'b1;
         for (int n = 0; n < 60; n++) begin
            tick();
            if (sys2) break;
         end
         lk2 = 1'b0;
         for (int n = 0; n < 60; n++) begin
            tick();
            if (!sys2) break;
         end
         check("sat_count", int'(cnt2), (i + 1 < 255) ? i + 1 : 255);
      end
      check("sat_final", int'(cnt2), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
